// File: rtl/mac_accumulate_stage_pkg.sv
// Shared constants, cfg encodings and FSM states
// for the MAC accumulate stage.
package mac_accumulate_stage_pkg;

   localparam int MAC_CONF_WIDTH = 2;
   localparam int MAC_MIN_WIDTH  = 8;
   localparam int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH;
   localparam int LEN_WIDTH      = 8;

   localparam logic [MAC_CONF_WIDTH-1:0] CFG_SINGLE = 2'b00;
   localparam logic [MAC_CONF_WIDTH-1:0] CFG_DUAL   = 2'b01;
   localparam logic [MAC_CONF_WIDTH-1:0] CFG_QUAD   = 2'b10;

   localparam int W_SINGLE = 2 * MAC_MIN_WIDTH + 4;
   localparam int W_DUAL   = 4 * MAC_MIN_WIDTH;
   localparam int W_QUAD   = 5 * MAC_MIN_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Reserved cfg 11 falls through to the full quad width.
   function automatic logic [MAC_INT_WIDTH-1:0] mode_mask(
      input logic [MAC_CONF_WIDTH-1:0] c
   );
      logic [MAC_INT_WIDTH-1:0] m;
      m = {MAC_INT_WIDTH{1'b1}};
      case (c)
         CFG_SINGLE: m = m >> (MAC_INT_WIDTH - W_SINGLE);
         CFG_DUAL:   m = m >> (MAC_INT_WIDTH - W_DUAL);
         default:    m = m >> (MAC_INT_WIDTH - W_QUAD);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mac_accumulate_stage_if.sv
// Product-in / result-out handshake bundle
// of the MAC accumulate stage.
interface mac_accumulate_stage_if;
   import mac_accumulate_stage_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [MAC_INT_WIDTH-1:0] prod;
   logic                     out_valid;
   logic                     out_ready;
   logic [MAC_INT_WIDTH-1:0] acc_out;
   logic                     ovf;

   modport master (
      output in_valid, prod, out_ready,
      input  in_ready, out_valid, acc_out, ovf
   );

   modport slave (
      input  in_valid, prod, out_ready,
      output in_ready, out_valid, acc_out, ovf
   );

endinterface

// File: rtl/mac_accumulate_stage_adder.sv
// Mode-width masked add with carry or
// signed-overflow detection.
module mac_acc_adder
   import mac_accumulate_stage_pkg::*;
(
   input  logic [MAC_INT_WIDTH-1:0]  i_acc,
   input  logic [MAC_INT_WIDTH-1:0]  i_prod,
   input  logic [MAC_CONF_WIDTH-1:0] i_cfg,
   output logic [MAC_INT_WIDTH-1:0]  o_sum,
   output logic                      o_ovf
);

   logic [MAC_INT_WIDTH-1:0] w_mask;
   logic [MAC_INT_WIDTH-1:0] w_a;
   logic [MAC_INT_WIDTH-1:0] w_b;
   logic [MAC_INT_WIDTH:0]   w_full;

   assign w_mask = mode_mask(i_cfg);
   assign w_a    = i_acc & w_mask;
   assign w_b    = i_prod & w_mask;
   assign w_full = {1'b0, w_a} + {1'b0, w_b};
   assign o_sum  = w_full[MAC_INT_WIDTH-1:0] & w_mask;

   always_comb begin
      o_ovf = 1'b0;
      unique case (1'b1)
         (i_cfg == CFG_SINGLE): o_ovf = w_full[W_SINGLE];
         (i_cfg == CFG_DUAL):   o_ovf = w_full[W_DUAL];
         i_cfg[1]:
            o_ovf = (w_a[W_QUAD-1] == w_b[W_QUAD-1]) &&
                    (o_sum[W_QUAD-1] != w_a[W_QUAD-1]);
      endcase
   end

endmodule

// File: rtl/mac_accumulate_stage.sv
// Accumulates len products into a mode-width
// dot product and hands it out over valid/ready.
module mac_accumulate_stage
   import mac_accumulate_stage_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [MAC_CONF_WIDTH-1:0] cfg,
   input  logic [LEN_WIDTH-1:0]      len,
   mac_accumulate_stage_if.slave     bus
);

   state_t                    r_state;
   logic [MAC_INT_WIDTH-1:0]  r_acc;
   logic [LEN_WIDTH-1:0]      r_cnt;
   logic [LEN_WIDTH-1:0]      r_len_q;
   logic [MAC_CONF_WIDTH-1:0] r_cfg_q;
   logic                      r_ovf;

   logic                      w_accept;
   logic [LEN_WIDTH-1:0]      w_len_eff;
   logic [LEN_WIDTH-1:0]      w_cnt_nxt;
   logic [MAC_INT_WIDTH-1:0]  w_first;
   logic [MAC_INT_WIDTH-1:0]  w_sum;
   logic                      w_add_ovf;

   assign bus.in_ready  = en & (r_state != HOLD);
   assign bus.out_valid = (r_state == HOLD);
   assign bus.acc_out   = r_acc;
   assign bus.ovf       = r_ovf;

   assign w_accept  = bus.in_valid & bus.in_ready;
   assign w_len_eff = (len == '0) ? LEN_WIDTH'(1) : len;
   assign w_cnt_nxt = r_cnt + LEN_WIDTH'(1);
   // The first product uses the live cfg, later ones the latched cfg.
   assign w_first   = bus.prod & mode_mask(cfg);

   mac_acc_adder u_adder (
      .i_acc  (r_acc),
      .i_prod (bus.prod),
      .i_cfg  (r_cfg_q),
      .o_sum  (w_sum),
      .o_ovf  (w_add_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_len_q <= '0;
         r_cfg_q <= CFG_SINGLE;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cfg_q <= cfg;
                  r_len_q <= w_len_eff;
                  r_acc   <= w_first;
                  r_cnt   <= LEN_WIDTH'(1);
                  r_ovf   <= 1'b0;
                  r_state <= (w_len_eff == LEN_WIDTH'(1)) ? HOLD : ACC;
               end
            end
            ACC: begin
               if (w_accept) begin
                  r_acc <= w_sum;
                  r_cnt <= w_cnt_nxt;
                  r_ovf <= r_ovf | w_add_ovf;
                  if (w_cnt_nxt == r_len_q) r_state <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Bench for mac_accumulate_stage: directed table,
// corner sequences and randomized dot products.
module tb_mac_accumulate_stage;
   import mac_accumulate_stage_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] cfg;
   logic [7:0] len;

   mac_accumulate_stage_if bus();

   mac_accumulate_stage dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .cfg (cfg),
      .len (len),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  cfg;
      logic [7:0]  len;
      int          n;
      logic [39:0] p0;
      logic [39:0] p1;
      logic [39:0] exp_acc;
      logic        exp_ovf;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [39:0] act,
                      input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns just after the
   // negedge following the accepting posedge.
   task automatic push(input logic [39:0] p);
      logic r;
      int   t;
      bus.in_valid = 1'b1;
      bus.prod     = p;
      t = 0;
      forever begin
         #1 r = bus.in_ready;
         @(posedge clk);
         @(negedge clk);
         if (r) break;
         t++;
         if (t >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got no accept expected accept");
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_dot(input string name, input logic [1:0] c,
                          input logic [7:0] l, input logic [39:0] q[$],
                          input logic [39:0] exp_acc, input logic exp_ovf,
                          input int stall);
      logic [39:0] held;
      cfg = c;
      len = l;
      bus.out_ready = (stall == 0);
      foreach (q[i]) begin
         push(q[i]);
         if (i == 0) begin
            cfg = 2'($urandom);
            len = 8'($urandom);
         end
      end
      chk({name, "_latency"}, 40'(bus.out_valid), 40'd1);
      held = bus.acc_out;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk({name, "_stall_valid"}, 40'(bus.out_valid), 40'd1);
         chk({name, "_stall_acc"}, bus.acc_out, held);
      end
      chk({name, "_acc"}, bus.acc_out, exp_acc);
      chk({name, "_ovf"}, 40'(bus.ovf), 40'(exp_ovf));
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_vfall"}, 40'(bus.out_valid), 40'd0);
   endtask

   // Reference: plain integer arithmetic, unsigned range or signed range.
   function automatic void model(input logic [1:0] c, input logic [39:0] q[$],
                                 output logic [39:0] acc, output logic ovf);
      longint s, lim, v;
      int     w;
      w   = (c == 2'd0) ? 20 : (c == 2'd1) ? 32 : 40;
      lim = longint'(1) <<< w;
      ovf = 1'b0;
      s   = 0;
      foreach (q[i]) begin
         if (w < 40) begin
            v = longint'(q[i]) % lim;
            s = s + v;
            if (s >= lim) begin
               ovf = 1'b1;
               s   = s - lim;
            end
         end else begin
            v = longint'(q[i]);
            if (v >= lim / 2) v = v - lim;
            s = s + v;
            if (s >= lim / 2) begin
               ovf = 1'b1;
               s   = s - lim;
            end else if (s < -(lim / 2)) begin
               ovf = 1'b1;
               s   = s + lim;
            end
         end
      end
      if (s < 0) s = s + lim;
      acc = s[39:0];
   endfunction

   initial begin
      logic [39:0] q[$];
      logic [39:0] e_acc;
      logic        e_ovf;
      int          n;

      tbl[0] = '{2'b00, 8'd3,  3,  40'hFFFF,       40'hFFFF,       40'h000002FFFD, 1'b0};
      tbl[1] = '{2'b00, 8'd17, 17, 40'hFFFF,       40'hFFFF,       40'h000000FFEF, 1'b1};
      tbl[2] = '{2'b01, 8'd2,  2,  40'hFFFFFF,     40'h1,          40'h0001000000, 1'b0};
      tbl[3] = '{2'b10, 8'd2,  2,  40'hFFFFFFFFFF, 40'h5,          40'h0000000004, 1'b0};
      tbl[4] = '{2'b10, 8'd2,  2,  40'h7FFFFFFFFF, 40'h1,          40'h8000000000, 1'b1};
      tbl[5] = '{2'b00, 8'd0,  1,  40'h0,          40'h1234,       40'h0000001234, 1'b0};
      tbl[6] = '{2'b11, 8'd2,  2,  40'h8000000000, 40'hFFFFFFFFFF, 40'h7FFFFFFFFF, 1'b1};
      tbl[7] = '{2'b01, 8'd2,  2,  40'hFFFFFFFF,   40'h2,          40'h0000000001, 1'b1};
      tbl[8] = '{2'b00, 8'd1,  1,  40'h0,          40'hFFF1234567, 40'h0000034567, 1'b0};

      rst = 1'b1;
      en  = 1'b1;
      cfg = 2'b00;
      len = 8'd1;
      bus.in_valid  = 1'b0;
      bus.prod      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 40'(bus.out_valid), 40'd0);
      chk("rst_acc", bus.acc_out, 40'd0);
      chk("rst_ovf", 40'(bus.ovf), 40'd0);
      chk("rst_ready", 40'(bus.in_ready), 40'd1);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         q.delete();
         for (int k = 0; k < tbl[i].n - 1; k++) q.push_back(tbl[i].p0);
         q.push_back(tbl[i].p1);
         run_dot($sformatf("tbl%0d", i), tbl[i].cfg, tbl[i].len, q,
                 tbl[i].exp_acc, tbl[i].exp_ovf, i % 2);
      end

      // Backpressure: held in_valid is not consumed in HOLD.
      cfg = 2'b00;
      len = 8'd1;
      bus.out_ready = 1'b0;
      push(40'h10);
      bus.in_valid = 1'b1;
      bus.prod     = 40'h55;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 40'(bus.out_valid), 40'd1);
         chk("bp_acc", bus.acc_out, 40'h10);
         chk("bp_ready", 40'(bus.in_ready), 40'd0);
         @(posedge clk);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_valid", 40'(bus.out_valid), 40'd0);
      chk("bp_idle_ready", 40'(bus.in_ready), 40'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_next_valid", 40'(bus.out_valid), 40'd1);
      chk("bp_next_acc", bus.acc_out, 40'h55);
      // en low must not block the output handshake.
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("en0_hold_done", 40'(bus.out_valid), 40'd0);
      en = 1'b1;

      // en stall mid-ACC.
      cfg = 2'b00;
      len = 8'd4;
      push(40'd1);
      push(40'd2);
      en = 1'b0;
      bus.in_valid = 1'b1;
      bus.prod     = 40'd100;
      for (int k = 0; k < 3; k++) begin
         #1 chk("stall_ready", 40'(bus.in_ready), 40'd0);
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      en = 1'b1;
      push(40'd3);
      chk("stall_cnt_hold", 40'(bus.out_valid), 40'd0);
      push(40'd4);
      chk("stall_valid", 40'(bus.out_valid), 40'd1);
      chk("stall_acc", bus.acc_out, 40'd10);
      @(posedge clk);
      @(negedge clk);

      // Reset mid-ACC discards the partial sum.
      cfg = 2'b00;
      len = 8'd4;
      push(40'd5);
      push(40'd6);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rstacc_valid", 40'(bus.out_valid), 40'd0);
      chk("rstacc_acc", bus.acc_out, 40'd0);
      chk("rstacc_ready", 40'(bus.in_ready), 40'd1);
      q.delete();
      q.push_back(40'd3);
      q.push_back(40'd4);
      run_dot("after_rst", 2'b00, 8'd2, q, 40'd7, 1'b0, 0);

      // Reset while holding a result.
      cfg = 2'b10;
      len = 8'd1;
      bus.out_ready = 1'b0;
      push(40'hFFFFFFFFFF);
      chk("rsthold_valid0", 40'(bus.out_valid), 40'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      chk("rsthold_valid", 40'(bus.out_valid), 40'd0);
      chk("rsthold_acc", bus.acc_out, 40'd0);

      for (int it = 0; it < 40; it++) begin
         logic [1:0]  c;
         logic [7:0]  l;
         logic [39:0] p;
         c = 2'($urandom_range(0, 3));
         l = 8'($urandom_range(0, 6));
         n = (l == 8'd0) ? 1 : int'(l);
         q.delete();
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 5))
               0:       p = 40'hFFFFFFFFFF;
               1:       p = 40'h7FFFFFFFFF;
               2:       p = 40'h8000000000;
               default: p = {8'($urandom), 32'($urandom)};
            endcase
            q.push_back(p);
         end
         model(c, q, e_acc, e_ovf);
         run_dot($sformatf("rnd%0d", it), c, l, q, e_acc, e_ovf,
                 $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_accumulate_stage.md
Name: mac_accumulate_stage

Overview:
Sequential accumulate stage directly downstream of mac_mul_block_1_experimental. It consumes that block's 40-bit combined product C, one product per accepted handshake, and sums a programmable number of products into a mode-width accumulator. It presents the finished dot product with a valid/ready handshake. Mode (single/dual/quad) uses the same cfg encoding as the multiply block.

Parameters:
MAC_CONF_WIDTH, 2, config bus width
MAC_MIN_WIDTH, 8, base lane width
MAC_INT_WIDTH, 5*MAC_MIN_WIDTH, product and accumulator bus width (40)
LEN_WIDTH, 8, width of the dot-product length field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  input-acceptance enable; does not gate the output handshake
cfg  in  MAC_CONF_WIDTH  00 single, 01 dual, 10 quad, 11 reserved (treated as quad)
len  in  LEN_WIDTH  number of products per dot product; sampled on the first accepted product
in_valid  in  1  prod is valid
in_ready  out  1  stage accepts prod this cycle
prod  in  MAC_INT_WIDTH  product from the multiply block (C)
out_valid  out  1  acc_out/ovf valid
out_ready  in  1  consumer takes the result
acc_out  out  MAC_INT_WIDTH  accumulated result, zero above the mode width
ovf  out  1  sticky overflow for the current dot product

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE; acc=0; cnt=0; len_q=0; cfg_q=00.
  - out_valid=0; ovf=0; acc_out=0.
  - in_ready=en in the first cycle after reset.
- Accept condition: accept = in_valid & in_ready. in_ready = en & (state != HOLD).
- Mode widths (W), fixed by cfg_q:
  - single: W=2*MIN+4=20, unsigned.
  - dual: W=4*MIN=32, unsigned.
  - quad: W=5*MIN=40, two's complement.
- Width rules:
  - prod is masked to W before the add.
  - The sum wraps modulo 2^W; bits at and above W are forced to 0.
- Overflow:
  - single/dual: carry out of bit W-1.
  - quad: signed overflow (both operands share a sign and the result sign differs).
  - ovf is ORed across the whole dot product and cleared on the first product.
- FSM:
  - IDLE:
    - On accept: cfg_q<=cfg; len_q<=max(len,1); acc<=mask(prod); cnt<=1; ovf<=0.
    - Next state is HOLD if max(len,1)==1, else ACC.
  - ACC:
    - On accept: acc<=mask(acc+prod); cnt<=cnt+1; ovf|=overflow.
    - Go to HOLD when cnt+1==len_q.
    - With no accept, all registers hold.
  - HOLD:
    - out_valid=1; acc_out=acc; in_ready=0.
    - When out_ready=1: go to IDLE; out_valid falls next cycle; acc and ovf keep their values until the next first product.
- Latency: out_valid rises the cycle after the final product is accepted. The minimum dot-product period is len_q+1 cycles with out_ready held high.
- Boundary conditions:
  - len=0 is treated as 1.
  - cfg and len changes after the first product are ignored.
  - in_valid during HOLD is not accepted; the upstream holds it.
  - en=0 stalls IDLE/ACC acceptance only; a HOLD handshake still completes.
  - rst in any state, including mid-ACC or HOLD, returns all registers to reset values next cycle. The partial sum is discarded.
- acc_out and out_valid are registered or pure state decode, with no combinational path from prod. in_ready is combinational from state and en only.

Decomposition:
- Add to the shared header mac_const.vh:
  - cfg encodings (CFG_SINGLE, CFG_DUAL, CFG_QUAD).
  - FSM state localparams (IDLE, ACC, HOLD).
  - mode-width constants.
- One sub-module is natural: mac_acc_adder, a combinational W-masked add plus overflow detect. It takes acc, prod and cfg_q and returns sum and ovf_bit, built on the existing n_bit_adder.

Test Plan:
- Single mode, len=3, three prods 40'h000000FFFF, out_ready=1 -> out_valid one cycle after the third accept; acc_out=40'h000002FFFD; ovf=0.
- Single mode, len=17, seventeen prods 40'hFFFF -> acc_out=40'h000000FFEF (20-bit wrap); ovf=1. Then dual mode, len=2, prods 24'hFFFFFF and 1 -> acc_out=40'h0001000000; ovf=0.
- Quad mode, len=2:
  - prods 40'hFFFFFFFFFF and 40'h0000000005 -> acc_out=40'h0000000004; ovf=0.
  - prods 40'h7FFFFFFFFF and 1 -> acc_out=40'h8000000000; ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 with prod 40'h55 -> out_valid stays 1; acc_out stays stable; in_ready=0; prod 40'h55 is not consumed. Release out_ready -> IDLE, and 40'h55 is accepted as the first product next cycle.
- len=0, single mode, prod 40'h1234 -> treated as len=1; out_valid next cycle; acc_out=40'h0000001234.
- Single mode, len=4:
  - en=0 for 3 cycles mid-ACC -> no accepts, cnt holds.
  - Assert rst after 2 accepts -> next cycle out_valid=0, acc_out=0, in_ready=1.
  - A fresh len=2 dot product of 3+4 then yields acc_out=7.
